// File: rtl/conv_stream_host.sv
// Host-side stream driver for the convolution accelerator.
// Streams input-feature and weight words from scratch memory into the
// accelerator load port, then writes the packed output words back to memory.
// o_fin_seen exposes the recorded accelerator-finish status bit.
module conv_stream_host #(
  parameter int ADDR_W    = 12,
  parameter int IN_WORDS  = 289,
  parameter int W_WORDS   = 36,
  parameter int OUT_WORDS = 256,
  parameter int IN_BASE   = 0,
  parameter int W_BASE    = 320,
  parameter int OUT_BASE  = 512
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_go,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_rd_addr,
  input  logic [31:0]       i_mem_rd_data,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_wr_addr,
  output logic [31:0]       o_mem_wr_data,
  output logic              o_acc_start,
  output logic [31:0]       o_acc_data,
  output logic              o_acc_valid,
  output logic              o_acc_d_type,
  input  logic [31:0]       i_acc_o_data,
  input  logic              i_acc_o_valid,
  input  logic              i_acc_finish,
  output logic              o_fin_seen
);

  localparam int CNT_W  = $clog2((IN_WORDS > W_WORDS) ? IN_WORDS : W_WORDS);
  localparam int OCNT_W = 9;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_FETCH_I = 3'd2;
  localparam logic [2:0] S_FETCH_W = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_COLLECT = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]        r_state;
  logic [2:0]        w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic [OCNT_W-1:0] r_outCnt;
  logic              r_rdValid1;
  logic              r_rdType1;
  logic              r_err;
  logic              r_finSeen;
  logic              w_goAccept;
  logic              w_lastIn;
  logic              w_lastW;
  logic              w_outAccept;
  logic [ADDR_W-1:0] w_rdBase;

  assign w_goAccept  = (r_state == S_IDLE) && i_go;
  assign w_lastIn    = (r_cnt == CNT_W'(IN_WORDS - 1));
  assign w_lastW     = (r_cnt == CNT_W'(W_WORDS - 1));
  assign w_outAccept = (r_state == S_COLLECT) && i_acc_o_valid &&
                       (r_outCnt != OCNT_W'(OUT_WORDS));

  assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done      = (r_state == S_DONE);
  assign o_acc_start = (r_state == S_START);
  assign o_err       = r_err;
  assign o_fin_seen  = r_finSeen;
  assign o_mem_rd_en = (r_state == S_FETCH_I) || (r_state == S_FETCH_W);
  assign w_rdBase    = (r_state == S_FETCH_W) ? ADDR_W'(W_BASE) : ADDR_W'(IN_BASE);
  assign o_mem_rd_addr = o_mem_rd_en ? (w_rdBase + ADDR_W'(r_cnt)) : '0;

  // Job sequencing: the drain exits once the final tagged word is on the port.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (i_go) w_nextState = S_START;
      S_START:   w_nextState = S_FETCH_I;
      S_FETCH_I: if (w_lastIn) w_nextState = S_FETCH_W;
      S_FETCH_W: if (w_lastW) w_nextState = S_DRAIN;
      S_DRAIN:   if (o_acc_valid && !r_rdValid1) w_nextState = S_COLLECT;
      S_COLLECT: if (o_mem_wr_en && (r_outCnt == OCNT_W'(OUT_WORDS)))
                   w_nextState = S_DONE;
      S_DONE:    w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  // State register and per-phase fetch counter (restarts between phases).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == S_FETCH_I && w_lastIn) || (r_state == S_FETCH_W && w_lastW))
        r_cnt <= '0;
      else if (o_mem_rd_en)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  // Two-stage load pipeline: memory latency, then the registered accelerator port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdValid1   <= 1'b0;
      r_rdType1    <= 1'b0;
      o_acc_valid  <= 1'b0;
      o_acc_data   <= '0;
      o_acc_d_type <= 1'b0;
    end else begin
      r_rdValid1   <= o_mem_rd_en;
      r_rdType1    <= (r_state == S_FETCH_W);
      o_acc_valid  <= r_rdValid1;
      o_acc_data   <= r_rdValid1 ? i_mem_rd_data : '0;
      o_acc_d_type <= r_rdValid1 & r_rdType1;
    end
  end

  // Output collection: each accepted word becomes a memory write one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_outCnt      <= '0;
      o_mem_wr_en   <= 1'b0;
      o_mem_wr_addr <= '0;
      o_mem_wr_data <= '0;
    end else begin
      o_mem_wr_en <= w_outAccept;
      if (w_goAccept) begin
        r_outCnt <= '0;
      end else if (w_outAccept) begin
        r_outCnt      <= r_outCnt + 1'b1;
        o_mem_wr_addr <= ADDR_W'(OUT_BASE) + ADDR_W'(r_outCnt);
        o_mem_wr_data <= i_acc_o_data;
      end
    end
  end

  // Sticky status: stray output words and the accelerator finish pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err     <= 1'b0;
      r_finSeen <= 1'b0;
    end else begin
      if (i_acc_o_valid && (r_state != S_COLLECT))
        r_err <= 1'b1;
      else if (w_goAccept)
        r_err <= 1'b0;
      if (w_goAccept)
        r_finSeen <= 1'b0;
      else if (i_acc_finish && o_busy)
        r_finSeen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_stream_host.sv
// Scoreboard bench for conv_stream_host: expected load words and memory
// writes are queued by the stimulus side and consumed by a negedge monitor.
module tb_conv_stream_host;

  localparam int ADDR_W    = 12;
  localparam int IN_WORDS  = 289;
  localparam int W_WORDS   = 36;
  localparam int OUT_WORDS = 256;
  localparam int IN_BASE   = 0;
  localparam int W_BASE    = 320;
  localparam int OUT_BASE  = 512;
  localparam int LOAD_WORDS = IN_WORDS + W_WORDS;

  logic              clk = 1'b0;
  logic              rstN;
  logic              go;
  logic              busy, done, err, finSeen;
  logic              memRdEn, memWrEn;
  logic [ADDR_W-1:0] memRdAddr, memWrAddr;
  logic [31:0]       memRdData, memWrData;
  logic              accStart, accValid, accDType;
  logic [31:0]       accData;
  logic [31:0]       accOData;
  logic              accOValid;
  logic              accFinish;
  logic [96:0]       allOut;

  logic [31:0] mem    [0:(1<<ADDR_W)-1];
  logic [31:0] outMem [0:(1<<ADDR_W)-1];

  logic [32:0] loadQ [$];
  logic [43:0] wrQ   [$];

  int total = 0;
  int bad   = 0;
  int validInJob = 0;
  int startInJob = 0;
  int wrInJob    = 0;
  int doneCount  = 0;
  logic prevValid = 1'b0;
  logic expDone   = 1'b0;

  conv_stream_host #(
    .ADDR_W(ADDR_W), .IN_WORDS(IN_WORDS), .W_WORDS(W_WORDS), .OUT_WORDS(OUT_WORDS),
    .IN_BASE(IN_BASE), .W_BASE(W_BASE), .OUT_BASE(OUT_BASE)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_go(go),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_mem_rd_en(memRdEn), .o_mem_rd_addr(memRdAddr), .i_mem_rd_data(memRdData),
    .o_mem_wr_en(memWrEn), .o_mem_wr_addr(memWrAddr), .o_mem_wr_data(memWrData),
    .o_acc_start(accStart), .o_acc_data(accData), .o_acc_valid(accValid),
    .o_acc_d_type(accDType), .i_acc_o_data(accOData), .i_acc_o_valid(accOValid),
    .i_acc_finish(accFinish), .o_fin_seen(finSeen)
  );

  always #5 clk = ~clk;

  assign allOut = {busy, done, err, memRdEn, memRdAddr, memWrEn, memWrAddr, memWrData,
                   accStart, accData, accValid, accDType, finSeen};

  // Scratch memory: one-cycle read latency, writes land in a separate image.
  always @(posedge clk) begin
    if (memRdEn) memRdData <= mem[memRdAddr];
    if (memWrEn) outMem[memWrAddr] <= memWrData;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents load words or writes.
  always @(negedge clk) begin
    if (!rstN) begin
      prevValid = 1'b0;
      expDone   = 1'b0;
    end else begin
      if (accStart) begin
        startInJob++;
        checkOutput("start_vs_valid", 64'(accValid), 64'd0);
      end
      if (accValid) begin
        validInJob++;
        if (loadQ.size() == 0) checkOutput("load_extra", 64'(accValid), 64'd0);
        else checkOutput("load_word", 64'({accDType, accData}), 64'(loadQ.pop_front()));
      end else if (prevValid) begin
        checkOutput("load_gap", 64'(loadQ.size()), 64'd0);
      end
      prevValid = accValid;
      if (memWrEn) begin
        wrInJob++;
        checkOutput("rd_wr_overlap", 64'(memRdEn), 64'd0);
        checkOutput("busy_in_write", 64'(busy), 64'd1);
        if (wrQ.size() == 0) checkOutput("write_unexpected", 64'(memWrEn), 64'd0);
        else checkOutput("write_word", 64'({memWrAddr, memWrData}), 64'(wrQ.pop_front()));
      end
      if (done || expDone) begin
        checkOutput("done_timing", 64'(done), 64'(expDone));
        if (done) begin
          doneCount++;
          checkOutput("busy_at_done", 64'(busy), 64'd0);
        end
      end
      expDone = memWrEn && (wrInJob == OUT_WORDS);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Request a job and queue the full expected load stream from the address map.
  task automatic pulseGo;
    loadQ.delete();
    for (int k = 0; k < IN_WORDS; k++) loadQ.push_back({1'b0, mem[IN_BASE + k]});
    for (int k = 0; k < W_WORDS; k++)  loadQ.push_back({1'b1, mem[W_BASE + k]});
    validInJob = 0;
    startInJob = 0;
    wrInJob    = 0;
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic waitLoad;
    int n = 0;
    while (validInJob < LOAD_WORDS && n < 2000) begin
      step();
      n++;
    end
    checkOutput("load_count", 64'(validInJob), 64'(LOAD_WORDS));
    step();
    step();
    checkOutput("start_pulses", 64'(startInJob), 64'd1);
    checkOutput("load_queue_drained", 64'(loadQ.size()), 64'd0);
  endtask

  // Feed all output words at random spacing, with a finish pulse after word 250.
  task automatic applyStimulus;
    for (int i = 0; i < OUT_WORDS; i++) begin
      repeat ($urandom_range(0, 5)) step();
      accOData  = 32'hA500_0000 + 32'(i);
      wrQ.push_back({ADDR_W'(OUT_BASE + i), accOData});
      accOValid = 1'b1;
      step();
      accOValid = 1'b0;
      if (i == 249) begin
        accFinish = 1'b1;
        step();
        accFinish = 1'b0;
      end
    end
  endtask

  task automatic waitDone;
    int startCount = doneCount;
    int n = 0;
    while (doneCount == startCount && n < 100) begin
      step();
      n++;
    end
    checkOutput("done_seen", 64'(doneCount - startCount), 64'd1);
    checkOutput("write_count", 64'(wrInJob), 64'(OUT_WORDS));
    checkOutput("fin_seen", 64'(finSeen), 64'd1);
    step();
    checkOutput("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic runJob;
    pulseGo();
    waitLoad();
    applyStimulus();
    waitDone();
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 32'(a);
    rstN = 1'b0; go = 1'b0; accOData = '0; accOValid = 1'b0; accFinish = 1'b0;

    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_outputs", 64'(|allOut), 64'd0);
    end
    @(posedge clk);
    #1 rstN = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle_outputs", 64'(|allOut), 64'd0);
    end
    step();

    $display("[TB] job 1: full load and collection");
    runJob();
    for (int i = 0; i < OUT_WORDS; i++)
      checkOutput("mem_image", 64'(outMem[OUT_BASE + i]), 64'(32'hA500_0000 + 32'(i)));
    checkOutput("err_clean", 64'(err), 64'd0);

    $display("[TB] job 2: stray output word during input fetch");
    pulseGo();
    begin
      int n = 0;
      while (validInJob < 5 && n < 100) begin
        step();
        n++;
      end
    end
    accOData = 32'hDEAD_BEEF;
    accOValid = 1'b1;
    step();
    accOValid = 1'b0;
    step();
    checkOutput("err_set", 64'(err), 64'd1);
    waitLoad();
    applyStimulus();
    waitDone();
    checkOutput("err_sticky", 64'(err), 64'd1);

    $display("[TB] job 3: go clears err");
    pulseGo();
    checkOutput("err_cleared", 64'(err), 64'd0);
    waitLoad();
    applyStimulus();
    waitDone();

    $display("[TB] job 4: reset during weight fetch");
    pulseGo();
    begin
      int n = 0;
      while (validInJob < IN_WORDS + 8 && n < 1000) begin
        step();
        n++;
      end
    end
    rstN = 1'b0;
    loadQ.delete();
    #1;
    checkOutput("async_reset_outputs", 64'(|allOut), 64'd0);
    repeat (3) step();
    rstN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_reset_idle", 64'(|allOut), 64'd0);
    end
    step();

    $display("[TB] job 5: restart after reset");
    runJob();

    checkOutput("write_queue_empty", 64'(wrQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
